// File: rtl/dmem_responder.sv
// Word-addressed data memory with req/ready handshake, programmable wait states and fault flagging.
// Optional build macro: DMEM_INIT_CLEAR_EN (zero the array after every reset release).
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        WE,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [32:0] ADDR_LIM  = 33'(4 * DEPTH_WORDS);

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;
  localparam state_t RESET_STATE = S_CLEAR;
  logic [AW-1:0] clr_q;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          fault_d;
  logic [AW-1:0] idx_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_widx_d;
  logic [31:0]   mem_wdata_d;

  // Fault and index decode from the captured address only.
  always_comb begin
    idx_d   = addr_q[AW+1:2];
    fault_d = (addr_q[1:0] != 2'd0) || ({1'b0, addr_q} >= ADDR_LIM);
  end

  // Write port: a reset-low edge never writes, which is what aborts an in-flight store.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_widx_d  = idx_d;
    mem_wdata_d = wdata_q;
`ifdef DMEM_INIT_CLEAR_EN
    if (state_q == S_CLEAR) begin
      mem_we_d    = reset;
      mem_widx_d  = clr_q;
      mem_wdata_d = 32'd0;
    end else begin
      mem_we_d = reset && (state_q == S_RESP) && we_q && !fault_d;
    end
`else
    mem_we_d = reset && (state_q == S_RESP) && we_q && !fault_d;
`endif
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_widx_d] <= mem_wdata_d;
    end
  end

  // Handshake FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= WE;
            addr_q  <= dataadr;
            wdata_q <= writedata;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          err_q   <= fault_d;
          rdata_q <= (!we_q && !fault_d) ? mem_q[idx_d] : 32'd0;
          state_q <= S_IDLE;
        end
`ifdef DMEM_INIT_CLEAR_EN
        S_CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == AW'(DEPTH_WORDS - 1)) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_CLEAR;
          end
        end
`endif
        default: begin
          state_q <= RESET_STATE;
        end
      endcase
    end
  end

  assign readdata = rdata_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule
